// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: walks a fetch PC, reads words from instruction
// memory over req/ack, and queues them in a small prefetch buffer for decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] MAX_PC   = 32'h0000_306c,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     PcReSet,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fpc, fpc_nxt, addr_nxt;
    logic [31:0]     target, fpc_inc;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [31:0]     buf_data [DEPTH];
    logic [31:0]     buf_pc   [DEPTH];
    logic            push, pop;

    assign target     = redirect_pc & ~32'd3;
    assign fpc_inc    = fpc + 32'd4;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    // Data returned while a redirect is in progress belongs to the old stream.
    assign push       = (state == REQ) & imem_ack & ~redirect;
    assign imem_req   = (state != IDLE);
    assign inst_out   = inst_valid ? buf_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : '0;
    assign buf_count  = count;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (redirect) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
            if (push && !pop)      count_nxt = count + CW'(1);
            else if (!push && pop) count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = imem_addr;
        fpc_nxt   = fpc;
        if (redirect)  fpc_nxt = target;
        else if (push) fpc_nxt = fpc_inc;

        case (state)
            IDLE: begin
                if (redirect) begin
                    if (target <= MAX_PC) begin
                        state_nxt = REQ;
                        addr_nxt  = target;
                    end
                end else if (count < FULL && fpc <= MAX_PC) begin
                    state_nxt = REQ;
                    addr_nxt  = fpc;
                end
            end
            REQ: begin
                // The request is held unchanged until acked; a redirect without
                // ack must still see the old request through, hence DROP.
                if (imem_ack) begin
                    if (redirect) begin
                        if (target <= MAX_PC) addr_nxt = target;
                        else                  state_nxt = IDLE;
                    end else if (count_nxt < FULL && fpc_inc <= MAX_PC) begin
                        addr_nxt = fpc_inc;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    if (fpc_nxt <= MAX_PC) begin
                        state_nxt = REQ;
                        addr_nxt  = fpc_nxt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            fpc       <= fpc_nxt;
            imem_addr <= addr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
        end
    end

    // Buffer storage is deliberately left unreset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= fpc;
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch front end and consumer of the program-counter address stream. It holds its own fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words go into a small prefetch buffer, which feeds decode over a valid/ready handshake. A redirect input (branch/jump target) flushes the buffer and restarts fetch; a stale in-flight read is discarded safely.

Parameters:
RESET_PC, 32'h0000_3000, fetch PC after reset
MAX_PC, 32'h0000_306c, last fetchable address (inclusive); no requests above it
DEPTH, 2, prefetch buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
PcReSet  in  1  reset, asynchronous, active-high
redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word address of request; registered
imem_ack  in  1  memory accepts the request; imem_rdata valid the same cycle
imem_rdata  in  32  instruction word
inst_valid  out  1  buffer head holds a valid instruction
inst_ready  in  1  decode accepts the head
inst_out  out  32  head instruction word; 0 when inst_valid=0
inst_pc  out  32  address of the head instruction; 0 when inst_valid=0
buf_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, PcReSet=1): state IDLE; fetch PC fpc=RESET_PC; imem_addr=RESET_PC; imem_req=0; buffer pointers and count=0; inst_valid=0; inst_out=0; inst_pc=0. Buffer storage is not reset.
- Reset mid-request abandons the transfer immediately: imem_req drops in the same cycle, with no wait for ack.
- FSM states: IDLE, REQ, DROP. imem_req=1 exactly in REQ and DROP.
- IDLE -> REQ when count<DEPTH, fpc<=MAX_PC and no redirect. On entry, imem_addr<=fpc.
- REQ: imem_req and imem_addr must stay stable until imem_ack=1 is sampled at a rising edge. On ack:
  - write {fpc, imem_rdata} at the buffer tail; fpc<=fpc+4.
  - If the post-edge count (including any same-cycle pop) is <DEPTH and fpc+4<=MAX_PC, stay in REQ with imem_addr<=fpc+4 (back-to-back fetch, one word per cycle at zero wait).
  - Otherwise go to IDLE.
- Only one request is outstanding at a time.
- Redirect:
  - Always: buffer flushed (count<=0, pointers<=0); fpc<=redirect_pc&~3.
  - In REQ with imem_ack=0: go to DROP. The request stays asserted with the old address (a request is never retracted).
  - In REQ with imem_ack=1 in the same cycle: returned data is discarded; next state is REQ at the new fpc if fpc<=MAX_PC, else IDLE.
  - In IDLE: go to REQ at the new fpc next cycle (if <=MAX_PC).
  - In DROP: update fpc and remain in DROP.
- DROP: on ack, discard data and go to REQ at fpc (or IDLE if fpc>MAX_PC). Nothing is ever written to the buffer from DROP.
- Output side:
  - inst_valid=(count!=0); inst_out/inst_pc come from the head entry.
  - Pop when inst_valid&inst_ready. Simultaneous push and pop leaves count unchanged.
  - A pop in the same cycle as redirect counts as a completed transfer; the flush wins for remaining entries.
- Latency: ack at edge N -> inst_valid high after edge N. From reset release: req asserted after the first edge, and the first inst_valid one edge after the first ack.
- Full: no request issued when count==DEPTH. An in-flight request always has a free slot because issue requires count<DEPTH.
- End of program: when fpc>MAX_PC no further requests are made. The buffer drains and inst_valid falls. A redirect to an address <=MAX_PC resumes fetch.
- Address arithmetic is 32-bit, wrapping modulo 2^32 (unreachable given MAX_PC).

Test Plan:
1. Reset release, memory acks in the same cycle as req, inst_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008...; one inst_valid per cycle; inst_pc matches; inst_out equals the memory model word.
2. inst_ready=0 from start -> two fetches (0x3000, 0x3004), buf_count=2, imem_req=0. Raise inst_ready -> pops 0x3000 then 0x3004; next request to 0x3008.
3. Memory ack delayed 3 cycles per request -> imem_req held high and imem_addr constant across wait cycles; no inst_valid until the cycle after ack.
4. Redirect with redirect_pc=0x3043 while the 0x3008 request is pending (no ack) -> DROP; imem_addr stays 0x3008 until ack; that data never appears. Next request is 0x3040; buffer empties in the redirect cycle; first post-flush inst_pc=0x3040.
5. Run to the end -> last request 0x306c, then imem_req stays 0 and inst_valid falls after drain. Redirect to 0x3000 -> fetch resumes at 0x3000.
6. Assert PcReSet while req is pending with buf_count=1 -> imem_req=0, inst_valid=0, buf_count=0 in the same cycle. After release, the first request is 0x3000.
